// File: rtl/univ_shift_reg.sv
// Universal shift register: load/shift/rotate/hold/clear with a multi-cycle
// shift sequencer that performs one bit per clock for amt steps.
//
// state | meaning
// IDLE  | waiting for start; single-edge ops and the first shift step happen here
// SHIFT | remaining steps counted down in cnt, one step per edge
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_LOAD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_SAR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_HOLD = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       mode_q, mode_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             sout_nxt;
  logic             done_nxt;
  logic [2:0]       step_mode;
  logic [WIDTH:0]   step_res;

  // One 1-bit step; result is {exiting bit, new register value}.
  function automatic logic [WIDTH:0] do_step(input logic [2:0] m,
                                             input logic [WIDTH-1:0] d,
                                             input logic s);
    logic [WIDTH:0] r;
    case (m)
      M_SHL:   r = {d[WIDTH-1], d[WIDTH-2:0], s};
      M_SHR:   r = {d[0], s, d[WIDTH-1:1]};
      M_SAR:   r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      M_ROL:   r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      M_ROR:   r = {d[0], d[0], d[WIDTH-1:1]};
      default: r = {1'b0, d};
    endcase
    return r;
  endfunction

  assign step_mode = (state == SHIFT) ? mode_q : mode;
  assign step_res  = do_step(step_mode, dout, sin);
  assign busy      = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    dout_nxt  = dout;
    sout_nxt  = sout;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (mode)
            M_LOAD: begin
              dout_nxt = din;
              done_nxt = 1'b1;
            end
            M_HOLD: done_nxt = 1'b1;
            M_CLR: begin
              dout_nxt = '0;
              done_nxt = 1'b1;
            end
            default: begin
              if (amt == CNT_W'(0)) begin
                done_nxt = 1'b1;
              end else begin
                {sout_nxt, dout_nxt} = step_res;
                if (amt == CNT_W'(1)) begin
                  done_nxt = 1'b1;
                end else begin
                  state_nxt = SHIFT;
                  cnt_nxt   = amt - CNT_W'(1);
                  mode_nxt  = mode;
                end
              end
            end
          endcase
        end
      end
      SHIFT: begin
        {sout_nxt, dout_nxt} = step_res;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= '0;
      dout   <= '0;
      sout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
      dout   <= dout_nxt;
      sout   <= sout_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: per-cycle vector table plus hand-written
// sequences for busy-ignore, reset mid-shift and over-width shift counts.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] mode;
  logic [3:0] amt;
  logic [7:0] din;
  logic       sin;
  logic [7:0] dout;
  logic       sout;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt),
    .din(din), .sin(sin), .dout(dout), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] din;
    logic       sin;
    logic [7:0] e_dout;
    logic       e_sout;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic r, input logic st, input logic [2:0] m,
                              input logic [3:0] a, input logic [7:0] d, input logic s,
                              input logic [7:0] ed, input logic es, input logic eb,
                              input logic edn);
    vec_t v;
    v.rst = r; v.start = st; v.mode = m; v.amt = a; v.din = d; v.sin = s;
    v.e_dout = ed; v.e_sout = es; v.e_busy = eb; v.e_done = edn;
    return v;
  endfunction

  // Drive one cycle of inputs, clock it, then compare all outputs.
  task automatic cyc(input logic r, input logic st, input logic [2:0] m,
                     input logic [3:0] a, input logic [7:0] d, input logic s,
                     input logic [7:0] ed, input logic es, input logic eb,
                     input logic edn, input string name);
    @(negedge clk);
    rst = r; start = st; mode = m; amt = a; din = d; sin = s;
    @(posedge clk);
    #1;
    checks++;
    if ({dout, sout, busy, done} !== {ed, es, eb, edn}) begin
      errors++;
      $display("FAIL %s: dout=%h sout=%b busy=%b done=%b, required dout=%h sout=%b busy=%b done=%b",
               name, dout, sout, busy, done, ed, es, eb, edn);
    end
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; mode = 3'b110; amt = 4'd0; din = 8'h00; sin = 1'b0;

    //           rst start mode    amt  din    sin   dout  sout busy done
    vecs[0]  = mk(1, 0, 3'b000, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0);
    vecs[1]  = mk(0, 1, 3'b000, 4'd0, 8'hA5, 0, 8'hA5, 0, 0, 1);
    vecs[2]  = mk(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'hA5, 0, 0, 0);
    vecs[3]  = mk(0, 1, 3'b001, 4'd3, 8'h00, 1, 8'h4B, 1, 1, 0);
    vecs[4]  = mk(0, 0, 3'b000, 4'd0, 8'h00, 1, 8'h97, 0, 1, 0);
    vecs[5]  = mk(0, 0, 3'b000, 4'd0, 8'h00, 1, 8'h2F, 1, 0, 1);
    vecs[6]  = mk(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'h2F, 1, 0, 0);
    vecs[7]  = mk(0, 1, 3'b000, 4'd0, 8'h80, 0, 8'h80, 1, 0, 1);
    vecs[8]  = mk(0, 1, 3'b011, 4'd2, 8'h00, 1, 8'hC0, 0, 1, 0);
    vecs[9]  = mk(0, 0, 3'b000, 4'd0, 8'h00, 1, 8'hE0, 0, 0, 1);
    vecs[10] = mk(0, 1, 3'b000, 4'd0, 8'h96, 0, 8'h96, 0, 0, 1);
    vecs[11] = mk(0, 1, 3'b101, 4'd8, 8'h00, 0, 8'h4B, 0, 1, 0);
    vecs[12] = mk(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'hA5, 1, 1, 0);
    vecs[13] = mk(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'hD2, 1, 1, 0);
    vecs[14] = mk(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'h69, 0, 1, 0);
    vecs[15] = mk(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'hB4, 1, 1, 0);
    vecs[16] = mk(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'h5A, 0, 1, 0);
    vecs[17] = mk(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'h2D, 0, 1, 0);
    vecs[18] = mk(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'h96, 1, 0, 1);
    vecs[19] = mk(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'h96, 1, 0, 0);
    vecs[20] = mk(0, 1, 3'b100, 4'd0, 8'h00, 0, 8'h96, 1, 0, 1);
    vecs[21] = mk(0, 1, 3'b010, 4'd1, 8'h00, 0, 8'h4B, 0, 0, 1);
    vecs[22] = mk(0, 1, 3'b111, 4'd0, 8'h00, 0, 8'h00, 0, 0, 1);
    vecs[23] = mk(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      cyc(vecs[i].rst, vecs[i].start, vecs[i].mode, vecs[i].amt, vecs[i].din,
          vecs[i].sin, vecs[i].e_dout, vecs[i].e_sout, vecs[i].e_busy,
          vecs[i].e_done, $sformatf("vec%0d", i));
    end

    // Start with clear during a rotate must be ignored
    cyc(0, 1, 3'b000, 4'd0, 8'h01, 0, 8'h01, 0, 0, 1, "ign_load");
    cyc(0, 1, 3'b100, 4'd3, 8'h00, 0, 8'h02, 0, 1, 0, "ign_step1");
    cyc(0, 1, 3'b111, 4'd0, 8'h00, 0, 8'h04, 0, 1, 0, "ign_step2");
    cyc(0, 1, 3'b111, 4'd0, 8'h00, 0, 8'h08, 0, 0, 1, "ign_step3");
    cyc(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'h08, 0, 0, 0, "ign_after");

    // Reset in the second busy cycle abandons the shift, no done pulse
    cyc(0, 1, 3'b000, 4'd0, 8'hFF, 0, 8'hFF, 0, 0, 1, "rst_load");
    cyc(0, 1, 3'b010, 4'd4, 8'h00, 0, 8'h7F, 1, 1, 0, "rst_step1");
    cyc(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'h3F, 1, 1, 0, "rst_step2");
    cyc(1, 1, 3'b000, 4'd0, 8'hAA, 0, 8'h00, 0, 0, 0, "rst_apply");
    cyc(0, 0, 3'b000, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, "rst_nodone");

    // Rotate by more than WIDTH wraps: ROL 9 of 0x01 gives 0x02
    cyc(0, 1, 3'b000, 4'd0, 8'h01, 0, 8'h01, 0, 0, 1, "wrap_load");
    cyc(0, 1, 3'b100, 4'd9, 8'h00, 0, 8'h02, 0, 1, 0, "wrap_step1");
    dones = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checks++;
    if ({dout, sout, busy, dones} !== {8'h02, 1'b0, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL wrap_end: dout=%h sout=%b busy=%b dones=%0d, required dout=02 sout=0 busy=0 dones=1",
               dout, sout, busy, dones);
    end

    // SHL by 10 with sin=1 from zero fills the register with ones
    cyc(0, 1, 3'b111, 4'd0, 8'h00, 0, 8'h00, 0, 0, 1, "fill_clr");
    cyc(0, 1, 3'b001, 4'd10, 8'h00, 1, 8'h01, 0, 1, 0, "fill_step1");
    dones = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checks++;
    if ({dout, sout, busy, dones} !== {8'hFF, 1'b1, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL fill_end: dout=%h sout=%b busy=%b dones=%0d, required dout=ff sout=1 busy=0 dones=1",
               dout, sout, busy, dones);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data register width, legal range >= 2.
REQ-002 The block SHALL have parameter CNT_W, default 4: shift-amount width, legal range >= 1.
REQ-003 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: operation request, sampled only when busy=0.
REQ-007 The block SHALL have port mode, input, 3 bits: operation select, sampled with start.
REQ-008 The block SHALL have port amt, input, CNT_W bits: shift count, sampled with start.
REQ-009 The block SHALL have port din, input, WIDTH bits: parallel load data.
REQ-010 The block SHALL have port sin, input, 1 bit: serial fill bit, sampled on every shift edge.
REQ-011 The block SHALL have port dout, output, WIDTH bits: registered register contents.
REQ-012 The block SHALL have port sout, output, 1 bit: registered copy of the last bit shifted or rotated out.
REQ-013 The block SHALL have port busy, output, 1 bit: registered; high while a multi-cycle shift is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: registered one-cycle completion pulse.

Function
REQ-015 mode encoding SHALL be: 000 load din; 001 SHL, LSB fill = sin; 010 SHR, MSB fill = sin; 011 SAR, MSB fill = current MSB; 100 ROL; 101 ROR; 110 hold; 111 clear to 0.
REQ-016 The FSM SHALL have two states, IDLE and SHIFT; busy = 1 exactly when in SHIFT.
REQ-017 A start sampled high in IDLE is accepted; start in SHIFT is ignored and mode/amt are not re-sampled.
REQ-018 Load, hold and clear SHALL complete at the accept edge: dout updates, done=1 for the next cycle, FSM stays IDLE, sout unchanged.
REQ-019 For shift/rotate modes with amt=N>0: first 1-bit step at the accept edge; remaining N-1 steps on the N-1 following edges, one bit per edge.
REQ-020 An internal down-counter SHALL hold the remaining steps; FSM enters SHIFT when N>1 and returns to IDLE on the edge performing step N.
REQ-021 done SHALL be 1 for exactly the one cycle following the edge of the final step; busy=0 in that cycle.
REQ-022 amt=0 with a shift/rotate mode SHALL leave dout and sout unchanged, with done pulsed as in REQ-018.
REQ-023 amt > WIDTH SHALL be legal; steps continue, rotates wrap modulo WIDTH, and SHL/SHR fill with sin on each step.
REQ-024 On every step, sout SHALL take the exiting bit: the pre-step MSB for SHL/ROL, the pre-step LSB for SHR/SAR/ROR.
REQ-025 A start in the done cycle SHALL be accepted (back-to-back operation, no idle gap).
REQ-026 Arithmetic SHALL be width-exact: no bit beyond WIDTH is stored, and no carry out exists other than sout.

Reset
REQ-027 When rst=1 at a clock edge, the next-state values SHALL be: dout=0, sout=0, busy=0, done=0, FSM=IDLE, counter=0.
REQ-028 rst SHALL override start and any in-progress shift; a reset mid-SHIFT abandons the operation with no done pulse.
REQ-029 After rst falls, the first start SHALL be accepted on the first edge with rst=0.

Verification (WIDTH=8, CNT_W=4)
REQ-030 Load: mode=000, din=0xA5, start -> dout=0xA5 after 1 edge; done high 1 cycle; busy never high.
REQ-031 SHL: from 0xA5, mode=001, amt=3, sin=1 -> dout 0x4B, 0x97, 0x2F on successive edges; sout=1; busy high 2 cycles; then done.
REQ-032 SAR: from 0x80, mode=011, amt=2 -> dout=0xE0, sout=0; then ROR amt=8 from 0x96 -> dout=0x96 after 8 edges, single done pulse.
REQ-033 Busy-ignore: start with mode=111 during a shift -> no effect; the shift completes normally.
REQ-034 Reset mid-shift: rst=1 in the 2nd SHIFT cycle -> next edge all outputs 0, FSM IDLE, no done pulse.
REQ-035 amt=0 with mode=100 -> dout unchanged, done pulse; back-to-back start in that done cycle accepted.
